// File: rtl/reg_writeback_arb_pkg.sv
// Shared types for the register file writeback path.
// Source ids and register index constants.
package reg_writeback_arb_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_LSU,
    WB_MDU
  } wb_src_e;

endpackage

// File: rtl/wb_starve_cnt.sv
// Saturating wait counter for a writeback source.
// Raises boost once the source has waited LIMIT cycles.
module wb_starve_cnt #(
  parameter int LIMIT = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             ready,
  output logic [CNT_W-1:0] cnt,
  output logic             boost
);

  logic sat;

  assign sat   = (cnt == CNT_W'(LIMIT));
  assign boost = valid && sat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!valid || ready) begin
      cnt <= '0;
    end else if (!sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reg_writeback_arb.sv
// Register file write port arbiter for ALU, LSU and MDU results.
// One grant per cycle; the winning result is registered for one cycle.
module reg_writeback_arb
  import reg_writeback_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8,
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic                  lsu_valid,
  input  logic                  mdu_valid,
  output logic                  alu_ready,
  output logic                  lsu_ready,
  output logic                  mdu_ready,
  input  logic [REG_IDX_W-1:0]  alu_rd,
  input  logic [REG_IDX_W-1:0]  lsu_rd,
  input  logic [REG_IDX_W-1:0]  mdu_rd,
  input  logic                  alu_fp,
  input  logic                  lsu_fp,
  input  logic                  mdu_fp,
  input  logic [DATA_WIDTH-1:0] alu_val,
  input  logic [DATA_WIDTH-1:0] lsu_val,
  input  logic [DATA_WIDTH-1:0] mdu_val,
  output logic                  regWrite,
  output logic [REG_IDX_W-1:0]  rd,
  output logic [DATA_WIDTH-1:0] rd_val,
  output logic                  f_en,
  output logic [CNT_W-1:0]      lsu_wait,
  output logic [CNT_W-1:0]      mdu_wait
);

  logic                  lsu_boost;
  logic                  mdu_boost;
  logic                  gnt;
  wb_src_e               sel;
  logic [REG_IDX_W-1:0]  m_rd;
  logic                  m_fp;
  logic [DATA_WIDTH-1:0] m_val;
  logic                  x0_wr;

  wb_starve_cnt #(
    .LIMIT(STARVE_LIMIT),
    .CNT_W(CNT_W)
  ) u_lsu_cnt (
    .clk  (clk),
    .rst  (rst),
    .valid(lsu_valid),
    .ready(lsu_ready),
    .cnt  (lsu_wait),
    .boost(lsu_boost)
  );

  wb_starve_cnt #(
    .LIMIT(STARVE_LIMIT),
    .CNT_W(CNT_W)
  ) u_mdu_cnt (
    .clk  (clk),
    .rst  (rst),
    .valid(mdu_valid),
    .ready(mdu_ready),
    .cnt  (mdu_wait),
    .boost(mdu_boost)
  );

  // Boosted sources first, then fixed ALU > LSU > MDU.
  always_comb begin
    gnt = 1'b0;
    sel = WB_ALU;
    if (!rst) begin
      gnt = 1'b0;
    end else if (lsu_boost) begin
      gnt = 1'b1;
      sel = WB_LSU;
    end else if (mdu_boost) begin
      gnt = 1'b1;
      sel = WB_MDU;
    end else if (alu_valid) begin
      gnt = 1'b1;
      sel = WB_ALU;
    end else if (lsu_valid) begin
      gnt = 1'b1;
      sel = WB_LSU;
    end else if (mdu_valid) begin
      gnt = 1'b1;
      sel = WB_MDU;
    end
  end

  assign alu_ready = gnt && (sel == WB_ALU);
  assign lsu_ready = gnt && (sel == WB_LSU);
  assign mdu_ready = gnt && (sel == WB_MDU);

  always_comb begin
    m_rd  = REG_ZERO;
    m_fp  = 1'b0;
    m_val = '0;
    unique case (sel)
      WB_ALU: begin
        m_rd  = alu_rd;
        m_fp  = alu_fp;
        m_val = alu_val;
      end
      WB_LSU: begin
        m_rd  = lsu_rd;
        m_fp  = lsu_fp;
        m_val = lsu_val;
      end
      WB_MDU: begin
        m_rd  = mdu_rd;
        m_fp  = mdu_fp;
        m_val = mdu_val;
      end
      default: begin
        m_rd  = REG_ZERO;
        m_fp  = 1'b0;
        m_val = '0;
      end
    endcase
  end

  // Integer x0 completes the handshake but is emitted as idle.
  assign x0_wr = (m_rd == REG_ZERO) && !m_fp;

  always_ff @(posedge clk) begin
    if (!rst) begin
      regWrite <= 1'b0;
      rd       <= REG_ZERO;
      rd_val   <= '0;
      f_en     <= 1'b0;
    end else if (gnt && !x0_wr) begin
      regWrite <= 1'b1;
      rd       <= m_rd;
      rd_val   <= m_val;
      f_en     <= m_fp;
    end else begin
      regWrite <= 1'b0;
      rd       <= REG_ZERO;
      rd_val   <= '0;
      f_en     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_writeback_arb.sv
// Self-checking bench for reg_writeback_arb.
// Behavioural model plus directed and random stimulus.
module tb_reg_writeback_arb;

  localparam int DW  = 32;
  localparam int LIM = 8;
  localparam int CW  = $clog2(LIM + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alu_valid = 1'b0;
  logic          lsu_valid = 1'b0;
  logic          mdu_valid = 1'b0;
  logic          alu_ready;
  logic          lsu_ready;
  logic          mdu_ready;
  logic [4:0]    alu_rd = '0;
  logic [4:0]    lsu_rd = '0;
  logic [4:0]    mdu_rd = '0;
  logic          alu_fp = 1'b0;
  logic          lsu_fp = 1'b0;
  logic          mdu_fp = 1'b0;
  logic [DW-1:0] alu_val = '0;
  logic [DW-1:0] lsu_val = '0;
  logic [DW-1:0] mdu_val = '0;
  logic          regWrite;
  logic [4:0]    rd;
  logic [DW-1:0] rd_val;
  logic          f_en;
  logic [CW-1:0] lsu_wait;
  logic [CW-1:0] mdu_wait;

  reg_writeback_arb #(
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .alu_valid(alu_valid),
    .lsu_valid(lsu_valid),
    .mdu_valid(mdu_valid),
    .alu_ready(alu_ready),
    .lsu_ready(lsu_ready),
    .mdu_ready(mdu_ready),
    .alu_rd   (alu_rd),
    .lsu_rd   (lsu_rd),
    .mdu_rd   (mdu_rd),
    .alu_fp   (alu_fp),
    .lsu_fp   (lsu_fp),
    .mdu_fp   (mdu_fp),
    .alu_val  (alu_val),
    .lsu_val  (lsu_val),
    .mdu_val  (mdu_val),
    .regWrite (regWrite),
    .rd       (rd),
    .rd_val   (rd_val),
    .f_en     (f_en),
    .lsu_wait (lsu_wait),
    .mdu_wait (mdu_wait)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int          m_lw = 0;
  int          m_mw = 0;
  int          g    = -1;
  logic        exp_we  = 1'b0;
  logic [4:0]  exp_rd  = '0;
  logic [31:0] exp_val = '0;
  logic        exp_f   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // -1 none, 0 ALU, 1 LSU, 2 MDU
  function automatic int pick();
    if (!rst) return -1;
    if (lsu_valid && m_lw == LIM) return 1;
    if (mdu_valid && m_mw == LIM) return 2;
    if (alu_valid) return 0;
    if (lsu_valid) return 1;
    if (mdu_valid) return 2;
    return -1;
  endfunction

  task automatic compare();
    @(negedge clk);
    g = pick();
    chk("alu_ready", {31'b0, alu_ready}, {31'b0, g == 0});
    chk("lsu_ready", {31'b0, lsu_ready}, {31'b0, g == 1});
    chk("mdu_ready", {31'b0, mdu_ready}, {31'b0, g == 2});
    chk("regWrite", {31'b0, regWrite}, {31'b0, exp_we});
    chk("rd", {27'b0, rd}, {27'b0, exp_rd});
    chk("rd_val", rd_val, exp_val);
    chk("f_en", {31'b0, f_en}, {31'b0, exp_f});
    chk("lsu_wait", 32'(lsu_wait), 32'(m_lw));
    chk("mdu_wait", 32'(mdu_wait), 32'(m_mw));
  endtask

  task automatic update();
    logic [4:0]  r;
    logic [31:0] v;
    logic        f;
    @(posedge clk);
    r = '0;
    v = '0;
    f = 1'b0;
    exp_we  = 1'b0;
    exp_rd  = '0;
    exp_val = '0;
    exp_f   = 1'b0;
    if (!rst) begin
      m_lw = 0;
      m_mw = 0;
    end else begin
      m_lw = (!lsu_valid || g == 1) ? 0 : ((m_lw < LIM) ? m_lw + 1 : LIM);
      m_mw = (!mdu_valid || g == 2) ? 0 : ((m_mw < LIM) ? m_mw + 1 : LIM);
      if (g == 0) begin r = alu_rd; v = alu_val; f = alu_fp; end
      if (g == 1) begin r = lsu_rd; v = lsu_val; f = lsu_fp; end
      if (g == 2) begin r = mdu_rd; v = mdu_val; f = mdu_fp; end
      if (g >= 0 && !(r == 5'd0 && !f)) begin
        exp_we  = 1'b1;
        exp_rd  = r;
        exp_val = v;
        exp_f   = f;
      end
    end
    #1;
    if (g == 0) alu_valid = 1'b0;
    if (g == 1) lsu_valid = 1'b0;
    if (g == 2) mdu_valid = 1'b0;
  endtask

  task automatic step();
    compare();
    update();
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset with every source asserting valid.
    alu_valid = 1'b1; alu_rd = 5'd1; alu_val = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_val = 32'h22;
    mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_val = 32'h33;
    repeat (3) step();
    chk("rst_regWrite", {31'b0, regWrite}, 32'd0);
    chk("rst_rd", {27'b0, rd}, 32'd0);
    chk("rst_rd_val", rd_val, 32'd0);
    chk("rst_f_en", {31'b0, f_en}, 32'd0);
    rst = 1'b1;
    alu_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0;
    step();

    // Single ALU write.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_val = 32'hDEADBEEF; alu_fp = 1'b0;
    #1 chk("single_alu_ready", {31'b0, alu_ready}, 32'd1);
    step();
    chk("single_we", {31'b0, regWrite}, 32'd1);
    chk("single_rd", {27'b0, rd}, 32'd5);
    chk("single_val", rd_val, 32'hDEADBEEF);
    chk("single_f_en", {31'b0, f_en}, 32'd0);
    step();
    chk("single_idle_we", {31'b0, regWrite}, 32'd0);
    chk("single_idle_rd", {27'b0, rd}, 32'd0);

    // Fixed priority order.
    alu_valid = 1'b1; alu_rd = 5'd1; alu_val = 32'hA1;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_val = 32'hB2; lsu_fp = 1'b0;
    mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_val = 32'hC3; mdu_fp = 1'b0;
    step();
    chk("prio_rd1", {27'b0, rd}, 32'd1);
    step();
    chk("prio_rd2", {27'b0, rd}, 32'd2);
    step();
    chk("prio_rd3", {27'b0, rd}, 32'd3);
    step();

    // MDU starved by a continuous ALU stream.
    alu_valid = 1'b1; alu_rd = 5'd10; alu_val = 32'h1000;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_val = 32'h900D; mdu_fp = 1'b0;
    for (int i = 1; i <= LIM; i++) begin
      step();
      chk("starve_wait", 32'(mdu_wait), 32'(i));
      alu_valid = 1'b1;
      alu_rd    = 5'(10 + i);
      alu_val   = $urandom;
    end
    #1;
    chk("starve_mdu_ready", {31'b0, mdu_ready}, 32'd1);
    chk("starve_alu_ready", {31'b0, alu_ready}, 32'd0);
    step();
    chk("starve_rd", {27'b0, rd}, 32'd9);
    chk("starve_val", rd_val, 32'h900D);
    chk("starve_wait_clr", 32'(mdu_wait), 32'd0);
    alu_valid = 1'b0;
    step();

    // x0 discarded, f0 written.
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_fp = 1'b0; lsu_val = 32'h55;
    #1 chk("x0_ready", {31'b0, lsu_ready}, 32'd1);
    step();
    chk("x0_we", {31'b0, regWrite}, 32'd0);
    chk("x0_val", rd_val, 32'd0);
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_fp = 1'b1; lsu_val = 32'h55;
    step();
    chk("f0_we", {31'b0, regWrite}, 32'd1);
    chk("f0_f_en", {31'b0, f_en}, 32'd1);
    chk("f0_rd", {27'b0, rd}, 32'd0);
    chk("f0_val", rd_val, 32'h55);
    step();

    // Reset lands on the edge that would load an ALU grant.
    alu_valid = 1'b1; alu_rd = 5'd7; alu_val = 32'h77; alu_fp = 1'b0;
    mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_val = 32'h44;
    #1 chk("midrst_ready", {31'b0, alu_ready}, 32'd1);
    compare();
    rst = 1'b0;
    update();
    chk("midrst_we", {31'b0, regWrite}, 32'd0);
    chk("midrst_rd", {27'b0, rd}, 32'd0);
    chk("midrst_lsu_wait", 32'(lsu_wait), 32'd0);
    chk("midrst_mdu_wait", 32'(mdu_wait), 32'd0);
    step();
    rst = 1'b1;
    alu_valid = 1'b0; mdu_valid = 1'b0;
    step();

    // Random traffic; sources hold payload until granted.
    for (int n = 0; n < 600; n++) begin
      if (!alu_valid) begin
        alu_valid = ($urandom_range(0, 99) < 70);
        alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        alu_fp    = 1'($urandom);
        alu_val   = $urandom;
      end
      if (!lsu_valid) begin
        lsu_valid = ($urandom_range(0, 99) < 50);
        lsu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        lsu_fp    = 1'($urandom);
        lsu_val   = $urandom;
      end
      if (!mdu_valid) begin
        mdu_valid = ($urandom_range(0, 99) < 50);
        mdu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        mdu_fp    = 1'($urandom);
        mdu_val   = $urandom;
      end
      rst = ($urandom_range(0, 79) != 0);
      step();
    end
    rst = 1'b1;
    alu_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
